// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC and squashes wrong-path fetches, including in-flight ones.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  branch_jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign pc_inc      = pc_q + 32'd4;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

  // Redirect target; code 0 refetches the current pc.
  always_comb begin
    tgt = pc_q;
    unique case (branch_jump)
      2'd1:    tgt = {branch_target[31:2], 2'b00};
      2'd2:    tgt = {jump_target[31:2], 2'b00};
      2'd3:    tgt = {jr_target[31:2], 2'b00};
      default: tgt = pc_q;
    endcase
  end

  // Next-state, IF/ID update and request decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    redir_d      = redir_q;
    imem_req     = !rst && (state_q != S_HOLD);
    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (flush) begin
            valid_d = 1'b0;
            instr_d = 32'd0;
            pc_d    = tgt;
          end else if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_inc;
            state_d      = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end else if (flush) begin
          valid_d = 1'b0;
          instr_d = 32'd0;
          redir_d = tgt;
          state_d = S_DRAIN;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = 32'd0;
        end
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        instr_d = 32'd0;
        if (flush) begin
          redir_d = tgt;
        end
        if (imem_ready) begin
          pc_d    = flush ? tgt : redir_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (flush) begin
          valid_d = 1'b0;
          instr_d = 32'd0;
          pc_d    = tgt;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RST_PC;
      instr_q      <= 32'd0;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      redir_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      redir_q      <= redir_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] RP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  branch_jump;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fetch_stage #(.RESET_PC(RP)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_jump   (branch_jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .flush         (flush),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  // Reference model: a held (skid) word and a pending squash target
  // are kept as queues; IF/ID and PC as plain variables.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [63:0] skidq[$];
  logic [31:0] drainq[$];

  function automatic logic m_req();
    return !rst && (skidq.size() == 0);
  endfunction

  task automatic drive(input logic r, input logic f, input logic s,
                       input logic [1:0] bj, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] jrt,
                       input logic rdy);
    @(negedge clk);
    rst = r; flush = f; stall = s; branch_jump = bj;
    branch_target = bt; jump_target = jt; jr_target = jrt;
    imem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    logic [31:0] t;
    logic [63:0] w;
    if (rst) begin
      m_pc = RP; m_instr = 0; m_pc4 = 0; m_valid = 0;
      skidq.delete(); drainq.delete();
    end else begin
      case (branch_jump)
        2'd1: t = branch_target & ~32'd3;
        2'd2: t = jump_target & ~32'd3;
        2'd3: t = jr_target & ~32'd3;
        default: t = m_pc;
      endcase
      if (skidq.size() != 0) begin
        if (flush) begin
          skidq.delete(); m_valid = 0; m_instr = 0; m_pc = t;
        end else if (!stall) begin
          w = skidq.pop_front();
          m_instr = w[63:32]; m_pc4 = w[31:0]; m_valid = 1;
          m_pc = m_pc + 4;
        end
      end else if (drainq.size() != 0) begin
        m_valid = 0; m_instr = 0;
        if (flush) begin
          drainq.delete(); drainq.push_back(t);
        end
        if (imem_ready) m_pc = drainq.pop_front();
      end else if (imem_ready) begin
        if (flush) begin
          m_valid = 0; m_instr = 0; m_pc = t;
        end else if (stall) begin
          skidq.push_back({mem(m_pc), m_pc + 32'd4});
        end else begin
          m_instr = mem(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
          m_pc = m_pc + 4;
        end
      end else if (flush) begin
        m_valid = 0; m_instr = 0; drainq.push_back(t);
      end else if (!stall) begin
        m_valid = 0; m_instr = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got=%b exp=0", imem_req);
    end
    tick();
    checks++;
    if (pc !== RP || if_id_valid !== 1'b0 ||
        if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state pc=%h v=%b i=%h p4=%h exp pc=%h zeros",
               pc, if_id_valid, if_id_instr, if_id_pc4, RP);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = RP + 32'(4 * k);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        failures++;
        $display("FAIL stream_addr req=%b addr=%h exp=%h",
                 imem_req, imem_addr, a);
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc4 !== a + 4 ||
          if_id_instr !== mem(a)) begin
        failures++;
        $display("FAIL stream_ifid v=%b p4=%h i=%h exp p4=%h i=%h",
                 if_id_valid, if_id_pc4, if_id_instr, a + 4, mem(a));
      end
    end
  endtask

  task automatic test_branch();
    drive(0, 1, 0, 2'd1, 32'h203, 0, 0, 1);
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 ||
        pc !== 32'h200) begin
      failures++;
      $display("FAIL branch_bubble v=%b i=%h pc=%h exp 0 0 200",
               if_id_valid, if_id_instr, pc);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL branch_addr got=%h exp=200", imem_addr);
    end
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h204 ||
        if_id_instr !== mem(32'h200)) begin
      failures++;
      $display("FAIL branch_ifid v=%b p4=%h i=%h exp p4=204",
               if_id_valid, if_id_pc4, if_id_instr);
    end
  endtask

  task automatic test_drain();
    drive(0, 1, 0, 2'd2, 0, 32'h40, 0, 1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, c == 0, 0, 2'd3, 0, 0, 32'h80, c == 3);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
        failures++;
        $display("FAIL drain_hold c=%0d req=%b addr=%h exp 1 40",
                 c, imem_req, imem_addr);
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_bubble c=%0d v=%b exp 0", c, if_id_valid);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_addr !== 32'h80) begin
      failures++;
      $display("FAIL drain_next got=%h exp=80", imem_addr);
    end
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h84) begin
      failures++;
      $display("FAIL drain_resume v=%b p4=%h exp 1 84",
               if_id_valid, if_id_pc4);
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 0, 0, 0, 0, 1);
    checks++;
    if (imem_addr !== 32'h84) begin
      failures++;
      $display("FAIL stall_addr got=%h exp=84", imem_addr);
    end
    tick();
    drive(0, 0, 1, 0, 0, 0, 0, 1);
    checks++;
    if (imem_req !== 1'b0 || if_id_pc4 !== 32'h84 ||
        if_id_instr !== mem(32'h80)) begin
      failures++;
      $display("FAIL stall_hold req=%b p4=%h exp 0 84",
               imem_req, if_id_pc4);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h88 ||
        if_id_instr !== mem(32'h84)) begin
      failures++;
      $display("FAIL stall_skid v=%b p4=%h i=%h exp p4=88",
               if_id_valid, if_id_pc4, if_id_instr);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h88) begin
      failures++;
      $display("FAIL stall_next req=%b addr=%h exp 1 88",
               imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_flush_hold();
    drive(0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 1, 2'd2, 0, 32'h300, 0, 1);
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 ||
        pc !== 32'h300) begin
      failures++;
      $display("FAIL hold_flush v=%b i=%h pc=%h exp 0 0 300",
               if_id_valid, if_id_instr, pc);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      failures++;
      $display("FAIL hold_next req=%b addr=%h exp 1 300",
               imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_wrap_reset();
    drive(0, 1, 0, 2'd2, 0, 32'hFFFF_FFFF, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr);
    end
    tick();
    checks++;
    if (pc !== 32'd0 || if_id_pc4 !== 32'd0 || if_id_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pc pc=%h p4=%h v=%b exp 0 0 1",
               pc, if_id_pc4, if_id_valid);
    end
    drive(0, 1, 0, 2'd1, 32'h500, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || pc !== RP) begin
      failures++;
      $display("FAIL rst_mid v=%b pc=%h exp 0 %h", if_id_valid, pc, RP);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RP) begin
      failures++;
      $display("FAIL rst_nodrain req=%b addr=%h exp 1 %h",
               imem_req, imem_addr, RP);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom,
            $urandom_range(0, 1) == 1);
      checks++;
      if (imem_req !== m_req() ||
          (m_req() && imem_addr !== m_pc)) begin
        failures++;
        $display("FAIL rand_req n=%0d req=%b addr=%h exp %b %h",
                 n, imem_req, imem_addr, m_req(), m_pc);
      end
      tick();
      checks++;
      if (pc !== m_pc || if_id_valid !== m_valid ||
          if_id_instr !== m_instr || if_id_pc4 !== m_pc4) begin
        failures++;
        $display("FAIL rand_state n=%0d pc=%h v=%b i=%h p4=%h exp %h %b %h %h",
                 n, pc, if_id_valid, if_id_instr, if_id_pc4,
                 m_pc, m_valid, m_instr, m_pc4);
      end
    end
  endtask

  initial begin
    rst = 1; flush = 0; stall = 0; branch_jump = 0;
    branch_target = 0; jump_target = 0; jr_target = 0;
    imem_ready = 0;
    test_reset();
    test_stream();
    test_branch();
    test_drain();
    test_stall();
    test_flush_hold();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
